// File: rtl/gray_pkg.sv
// Shared definitions for the gray-code receive path: FSM encodings and wrap counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam int unsigned       WRAPCNT_W   = 8;
    localparam logic [WRAPCNT_W-1:0] WRAPCNT_MAX = 8'd255;

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary conversion.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: gray (in, WIDTH) gray-coded word; binary (out, WIDTH) decoded value.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    // Each binary bit is the XOR of all gray bits at or above it, which is the
    // unrolled form of b[i] = b[i+1] ^ g[i] and avoids a self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign binary[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_decoder.sv
// Gray stream monitor: decodes sampled Gray, tracks single forward steps, flags illegal
// transitions (sticky) and pulses Wrap on max->0. Latency: 1 cycle, all outputs registered.
// Backpressure: none; En is a sample strobe, Clear overrides En and drops that cycle's sample.
// Ports: Clk, Reset_n (async active-low), En, Clear, Gray[WIDTH] in;
//        Binary[WIDTH], Valid, Wrap, StepErr out; WrapCnt[8] out when GRAY_DEC_WRAPCNT_EN is defined.
// Optional feature macro: GRAY_DEC_WRAPCNT_EN (saturating count of Wrap pulses).
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 En,
    input  logic                 Clear,
    input  logic [WIDTH-1:0]     Gray,
    output logic [WIDTH-1:0]     Binary,
    output logic                 Valid,
    output logic                 Wrap,
`ifdef GRAY_DEC_WRAPCNT_EN
    output logic [WRAPCNT_W-1:0] WrapCnt,
`endif
    output logic                 StepErr
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] bin_q, bin_nxt;
    logic [WIDTH-1:0] prev_gray, prev_gray_nxt;
    logic             wrap_q, wrap_nxt;
    logic             err_q, err_nxt;
    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] bin_inc;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray   (Gray),
        .binary (gray_bin)
    );

    // Expected next value; wraps modulo 2^WIDTH naturally.
    assign bin_inc = bin_q + ONE;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            bin_q     <= '0;
            prev_gray <= '0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            bin_q     <= bin_nxt;
            prev_gray <= prev_gray_nxt;
            wrap_q    <= wrap_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bin_nxt       = bin_q;
        prev_gray_nxt = prev_gray;
        wrap_nxt      = 1'b0;
        err_nxt       = err_q;
        if (Clear) begin
            // Binary is kept; it is re-captured on the next accepted sample.
            state_nxt = ST_IDLE;
            err_nxt   = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (En) begin
                        prev_gray_nxt = Gray;
                        bin_nxt       = gray_bin;
                        state_nxt     = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (En) begin
                        if (Gray == prev_gray) begin
                            // Stalled counter: legal, nothing changes.
                        end else if (gray_bin == bin_inc) begin
                            prev_gray_nxt = Gray;
                            bin_nxt       = gray_bin;
                            wrap_nxt      = (bin_q == BIN_MAX);
                        end else begin
                            // Backward steps, skips and multi-bit changes all land here;
                            // Binary and prev_gray keep the last good sample.
                            state_nxt = ST_FAULT;
                            err_nxt   = 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    // Only Clear or reset leave this state.
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign Binary  = bin_q;
    assign Valid   = (state == ST_LOCKED);
    assign Wrap    = wrap_q;
    assign StepErr = err_q;

`ifdef GRAY_DEC_WRAPCNT_EN
    logic [WRAPCNT_W-1:0] wrap_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wrap_cnt <= '0;
        end else if (Clear) begin
            wrap_cnt <= '0;
        end else if (wrap_nxt && (wrap_cnt != WRAPCNT_MAX)) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end

    assign WrapCnt = wrap_cnt;
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder (WIDTH=3): directed vectors push expected outputs into a scoreboard;
// a monitor pops one entry per clock edge and compares.
module tb_gray_decoder;

    logic       Clk;
    logic       Reset_n;
    logic       En;
    logic       Clear;
    logic [2:0] Gray;
    logic [2:0] Binary;
    logic       Valid;
    logic       Wrap;
    logic       StepErr;
`ifdef GRAY_DEC_WRAPCNT_EN
    logic [7:0] WrapCnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] bin;
        logic       vld;
        logic       wrap;
        logic       err;
        string      name;
    } exp_t;

    exp_t sb[$];

    gray_decoder #(.WIDTH(3)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .En      (En),
        .Clear   (Clear),
        .Gray    (Gray),
        .Binary  (Binary),
        .Valid   (Valid),
        .Wrap    (Wrap),
`ifdef GRAY_DEC_WRAPCNT_EN
        .WrapCnt (WrapCnt),
`endif
        .StepErr (StepErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; the pushed expectation
    // describes the outputs right after the following rising edge.
    task automatic step(input logic en, input logic clr, input logic [2:0] g,
                        input logic [2:0] eb, input logic ev, input logic ew,
                        input logic ee, input string nm);
        exp_t e;
        @(negedge Clk);
        En = en; Clear = clr; Gray = g;
        e.bin = eb; e.vld = ev; e.wrap = ew; e.err = ee; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drive(input logic en, input logic clr, input logic [2:0] g);
        @(negedge Clk);
        En = en; Clear = clr; Gray = g;
    endtask

    // Monitor: registered outputs are examined 1 ns after each rising edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".Binary"},  32'(Binary),  32'(e.bin));
            chk({e.name, ".Valid"},   32'(Valid),   32'(e.vld));
            chk({e.name, ".Wrap"},    32'(Wrap),    32'(e.wrap));
            chk({e.name, ".StepErr"}, 32'(StepErr), 32'(e.err));
        end
    end

    initial begin
        int budget;
        En = 1'b0; Clear = 1'b0; Gray = 3'b000;
        Reset_n = 1'b0;
        #3;
        chk("rst.Binary", 32'(Binary), 0);
        chk("rst.Valid", 32'(Valid), 0);
        chk("rst.Wrap", 32'(Wrap), 0);
        chk("rst.StepErr", 32'(StepErr), 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // Full forward cycle with wrap on 100 -> 000.
        step(0, 0, 3'b000, 3'd0, 0, 0, 0, "idle");
        step(1, 0, 3'b000, 3'd0, 1, 0, 0, "seq_g000");
        step(1, 0, 3'b001, 3'd1, 1, 0, 0, "seq_g001");
        step(1, 0, 3'b011, 3'd2, 1, 0, 0, "seq_g011");
        step(1, 0, 3'b010, 3'd3, 1, 0, 0, "seq_g010");
        step(1, 0, 3'b110, 3'd4, 1, 0, 0, "seq_g110");
        step(1, 0, 3'b111, 3'd5, 1, 0, 0, "seq_g111");
        step(1, 0, 3'b101, 3'd6, 1, 0, 0, "seq_g101");
        step(1, 0, 3'b100, 3'd7, 1, 0, 0, "seq_g100");
        step(1, 0, 3'b000, 3'd0, 1, 1, 0, "seq_wrap");
        step(0, 0, 3'b000, 3'd0, 1, 0, 0, "seq_wrap_end");

        // Stall with En=1, then En=0 with a foreign code.
        step(0, 1, 3'b000, 3'd0, 0, 0, 0, "hold_clear");
        step(1, 0, 3'b000, 3'd0, 1, 0, 0, "hold_g000");
        step(1, 0, 3'b001, 3'd1, 1, 0, 0, "hold_g001");
        step(1, 0, 3'b011, 3'd2, 1, 0, 0, "hold_g011");
        for (int i = 0; i < 5; i++) step(1, 0, 3'b011, 3'd2, 1, 0, 0, "hold_stall");
        for (int i = 0; i < 3; i++) step(0, 0, 3'b110, 3'd2, 1, 0, 0, "hold_en0");

        // Backward step from 011 (b=2) to 001.
        step(1, 0, 3'b001, 3'd2, 0, 0, 1, "back_err");
        step(1, 0, 3'b010, 3'd2, 0, 0, 1, "back_ignored1");
        step(1, 0, 3'b110, 3'd2, 0, 0, 1, "back_ignored2");
        step(0, 1, 3'b110, 3'd2, 0, 0, 0, "back_clear");
        step(1, 0, 3'b110, 3'd4, 1, 0, 0, "back_recap");
        step(1, 0, 3'b111, 3'd5, 1, 0, 0, "back_next");

        // Two-bit change, then Clear and En together.
        step(0, 1, 3'b000, 3'd5, 0, 0, 0, "two_clear");
        step(1, 0, 3'b000, 3'd0, 1, 0, 0, "two_g000");
        step(1, 0, 3'b011, 3'd0, 0, 0, 1, "two_err");
        step(1, 1, 3'b001, 3'd0, 0, 0, 0, "two_clr_en");
        step(0, 0, 3'b001, 3'd0, 0, 0, 0, "two_dropped");
        step(1, 0, 3'b010, 3'd3, 1, 0, 0, "two_recap");
        step(1, 0, 3'b110, 3'd4, 1, 0, 0, "two_next");

        // Skip (b 4 -> 6) faults too.
        step(1, 0, 3'b101, 3'd4, 0, 0, 1, "skip_err");

        // Asynchronous reset between edges, checked before any edge.
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst.Binary", 32'(Binary), 0);
        chk("arst.Valid", 32'(Valid), 0);
        chk("arst.Wrap", 32'(Wrap), 0);
        chk("arst.StepErr", 32'(StepErr), 0);
        En = 1'b0; Clear = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        step(1, 0, 3'b011, 3'd2, 1, 0, 0, "post_rst_cap");
        step(0, 0, 3'b011, 3'd2, 1, 0, 0, "post_rst_idle");

`ifdef GRAY_DEC_WRAPCNT_EN
        begin
            logic [2:0] gseq [8];
            gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
            drive(0, 1, 3'b000);
            for (int r = 0; r < 260; r++)
                for (int k = 0; k < 8; k++) drive(1, 0, gseq[k]);
            drive(1, 0, 3'b000);
            drive(0, 0, 3'b000);
            @(posedge Clk); #1;
            chk("wrapcnt_sat", 32'(WrapCnt), 255);
            drive(0, 1, 3'b000);
            @(posedge Clk); #1;
            chk("wrapcnt_clear", 32'(WrapCnt), 0);
            drive(0, 0, 3'b000);
        end
`endif

        budget = 100;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge Clk);
            budget--;
        end
        #2;
        if (sb.size() > 0) begin
            chk("scoreboard_drain", 32'(sb.size()), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
